// File: rtl/window_seq_pkg.sv
// Shared types and constants for the window sequencer: FSM states,
// row-select reset phase and position-counter width.
package window_seq_pkg;

   localparam int unsigned CNT_W = 9;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } seq_state_e;

   localparam logic [4:0] ASEL_RESET = 5'b00100;
   localparam logic [2:0] HSEL_RESET = 3'd2;
   localparam logic [4:0] ASEL_FIRST = 5'b00001;

   function automatic logic is_onehot5(input logic [4:0] v);
      return (v != '0) && ((v & (v - 5'd1)) == '0);
   endfunction

endpackage

// File: rtl/line_phase_rotator.sv
// Row-buffer write select (one-hot) and vertical tap phase, both stepped
// once per completed line and preserved across frames.
module line_phase_rotator
   import window_seq_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       advance,
   output logic [4:0] asel,
   output logic [2:0] hsel
);

   logic [4:0] asel_q, asel_d;
   logic [2:0] hsel_q, hsel_d;

   always_comb begin
      asel_d = asel_q;
      hsel_d = hsel_q;
      if (advance) begin
         // a corrupted select falls back to the first row rather than staying stuck
         if (is_onehot5(asel_q)) begin
            asel_d = {asel_q[3:0], asel_q[4]};
         end else begin
            asel_d = ASEL_FIRST;
         end
         hsel_d = (hsel_q >= 3'd4) ? '0 : hsel_q + 3'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         asel_q <= ASEL_RESET;
         hsel_q <= HSEL_RESET;
      end else begin
         asel_q <= asel_d;
         hsel_q <= hsel_d;
      end
   end

   assign asel = asel_q;
   assign hsel = hsel_q;

endmodule

// File: rtl/window_sequencer.sv
// Frame sequencer for a 5x5 window: forwards one frame of pixels, appends
// blanking lines to drain the window, and tracks line position and phase.
module window_sequencer
   import window_seq_pkg::*;
#(
   parameter int unsigned WIDTH       = 420,
   parameter int unsigned HEIGHT      = 300,
   parameter int unsigned FLUSH_LINES = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       src_valid,
   input  logic [7:0] src_data,
   output logic       src_ready,
   output logic [7:0] win_din,
   output logic       win_valid,
   output logic       win_blank,
   output logic [4:0] asel,
   output logic [2:0] hsel,
   output logic [8:0] x_count,
   output logic [8:0] y_count,
   output logic       border,
   output logic       frame_done,
   output logic       busy
);

   localparam cnt_t X_LAST       = cnt_t'(WIDTH - 1);
   localparam cnt_t Y_LAST       = cnt_t'(HEIGHT - 1);
   localparam cnt_t Y_FLUSH_LAST = cnt_t'(HEIGHT + FLUSH_LINES - 1);
   localparam cnt_t EDGE_LO      = cnt_t'(2);
   localparam cnt_t X_EDGE_HI    = cnt_t'(WIDTH - 3);
   localparam cnt_t Y_EDGE_HI    = cnt_t'(HEIGHT - 3);

   seq_state_e state_q, state_d;
   cnt_t       px_q, px_d;
   cnt_t       py_q, py_d;
   cnt_t       x_count_q, x_count_d;
   cnt_t       y_count_q, y_count_d;
   logic [7:0] win_din_q, win_din_d;
   logic       win_valid_q, win_valid_d;
   logic       win_blank_q, win_blank_d;
   logic       border_q, border_d;
   logic       emit;
   logic       advance;
   logic       line_end;

   // px/py point at the next pixel to emit; x_count/y_count hold the one on win_*
   always_comb begin
      state_d     = state_q;
      px_d        = px_q;
      py_d        = py_q;
      x_count_d   = x_count_q;
      y_count_d   = y_count_q;
      win_din_d   = win_din_q;
      win_valid_d = 1'b0;
      win_blank_d = 1'b0;
      border_d    = 1'b0;
      emit        = 1'b0;
      advance     = 1'b0;
      line_end    = (px_q == X_LAST);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (src_valid) begin
               emit      = 1'b1;
               win_din_d = src_data;
               if (line_end && (py_q == Y_LAST)) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            emit        = 1'b1;
            win_din_d   = '0;
            win_blank_d = 1'b1;
            if (line_end && (py_q == Y_FLUSH_LAST)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d   = ST_IDLE;
            px_d      = '0;
            py_d      = '0;
            x_count_d = '0;
            y_count_d = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (emit) begin
         win_valid_d = 1'b1;
         x_count_d   = px_q;
         y_count_d   = py_q;
         border_d    = win_blank_d || (px_q < EDGE_LO) || (px_q > X_EDGE_HI) ||
                       (py_q < EDGE_LO) || (py_q > Y_EDGE_HI);
         if (line_end) begin
            px_d    = '0;
            py_d    = py_q + cnt_t'(1);
            advance = 1'b1;
         end else begin
            px_d = px_q + cnt_t'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         px_q        <= '0;
         py_q        <= '0;
         x_count_q   <= '0;
         y_count_q   <= '0;
         win_din_q   <= '0;
         win_valid_q <= 1'b0;
         win_blank_q <= 1'b0;
         border_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         px_q        <= px_d;
         py_q        <= py_d;
         x_count_q   <= x_count_d;
         y_count_q   <= y_count_d;
         win_din_q   <= win_din_d;
         win_valid_q <= win_valid_d;
         win_blank_q <= win_blank_d;
         border_q    <= border_d;
      end
   end

   line_phase_rotator u_rotator (
      .clock   (clock),
      .reset_n (reset_n),
      .advance (advance),
      .asel    (asel),
      .hsel    (hsel)
   );

   assign src_ready  = (state_q == ST_RUN);
   assign busy       = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign frame_done = (state_q == ST_DONE);
   assign win_din    = win_din_q;
   assign win_valid  = win_valid_q;
   assign win_blank  = win_blank_q;
   assign border     = border_q;
   assign x_count    = x_count_q;
   assign y_count    = y_count_q;

endmodule

// File: tb/tb_window_sequencer.sv
// Directed scoreboard bench for window_sequencer at an 8x6 frame with two
// blanking lines.
module tb_window_sequencer;
   import window_seq_pkg::*;

   localparam int unsigned W = 8;
   localparam int unsigned H = 6;
   localparam int unsigned F = 2;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       start;
   logic       src_valid;
   logic [7:0] src_data;
   logic       src_ready;
   logic [7:0] win_din;
   logic       win_valid;
   logic       win_blank;
   logic [4:0] asel;
   logic [2:0] hsel;
   logic [8:0] x_count;
   logic [8:0] y_count;
   logic       border;
   logic       frame_done;
   logic       busy;

   window_sequencer #(.WIDTH(W), .HEIGHT(H), .FLUSH_LINES(F)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .src_ready  (src_ready),
      .win_din    (win_din),
      .win_valid  (win_valid),
      .win_blank  (win_blank),
      .asel       (asel),
      .hsel       (hsel),
      .x_count    (x_count),
      .y_count    (y_count),
      .border     (border),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] din;
      logic       blank;
      logic [8:0] x;
      logic [8:0] y;
      logic       border;
   } exp_pix_t;

   exp_pix_t   sb_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   seq_state_e m_state;
   int         mx, my, m_xc, m_yc, wraps;
   logic [4:0] m_asel;
   logic [2:0] m_hsel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = ST_IDLE;
      mx = 0; my = 0; m_xc = 0; m_yc = 0; wraps = 0;
      m_asel = 5'b00100;
      m_hsel = 3'd2;
      sb_q.delete();
   endtask

   task automatic check_reset_values();
      chk("rst_win_din",    win_din,    8'h00);
      chk("rst_win_valid",  win_valid,  1'b0);
      chk("rst_win_blank",  win_blank,  1'b0);
      chk("rst_border",     border,     1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_busy",       busy,       1'b0);
      chk("rst_src_ready",  src_ready,  1'b0);
      chk("rst_x_count",    x_count,    9'd0);
      chk("rst_y_count",    y_count,    9'd0);
      chk("rst_asel",       asel,       5'b00100);
      chk("rst_hsel",       hsel,       3'd2);
   endtask

   // One clock: check state-decoded outputs, drive inputs, advance model,
   // then compare the registered outputs after the edge.
   task automatic step(input logic sv, input logic [7:0] sd, input logic st);
      exp_pix_t e;
      exp_pix_t got;
      logic     emit;
      logic     blank;
      logic     wrapped;
      emit = 1'b0; blank = 1'b0; wrapped = 1'b0;
      chk("src_ready",  src_ready,  m_state == ST_RUN);
      chk("busy",       busy,       (m_state == ST_RUN) || (m_state == ST_FLUSH));
      chk("frame_done", frame_done, m_state == ST_DONE);
      src_valid = sv; src_data = sd; start = st;
      case (m_state)
         ST_IDLE:  if (st) m_state = ST_RUN;
         ST_RUN:   emit = sv;
         ST_FLUSH: begin emit = 1'b1; blank = 1'b1; end
         default: begin
            m_state = ST_IDLE;
            mx = 0; my = 0; m_xc = 0; m_yc = 0;
         end
      endcase
      if (emit) begin
         e.din    = blank ? 8'h00 : sd;
         e.blank  = blank;
         e.x      = 9'(mx);
         e.y      = 9'(my);
         e.border = blank || (mx < 2) || (mx > int'(W) - 3) || (my < 2) || (my > int'(H) - 3);
         sb_q.push_back(e);
         m_xc = mx; m_yc = my;
         if (mx == int'(W) - 1) begin
            if (m_state == ST_RUN && my == int'(H) - 1) m_state = ST_FLUSH;
            else if (m_state == ST_FLUSH && my == int'(H + F) - 1) m_state = ST_DONE;
            mx = 0; my++; wraps++; wrapped = 1'b1;
            m_asel = {m_asel[3:0], m_asel[4]};
            m_hsel = (m_hsel == 3'd4) ? 3'd0 : m_hsel + 3'd1;
         end else begin
            mx++;
         end
      end
      @(posedge clock);
      @(negedge clock);
      chk("win_valid", win_valid, emit);
      chk("x_count",   x_count,   9'(m_xc));
      chk("y_count",   y_count,   9'(m_yc));
      chk("asel",      asel,      m_asel);
      chk("hsel",      hsel,      m_hsel);
      if (emit) begin
         got = sb_q.pop_front();
         chk("win_din",   win_din,   got.din);
         chk("win_blank", win_blank, got.blank);
         chk("border",    border,    got.border);
         if (got.blank == 1'b0 && got.x == 9'd1 && got.y == 9'd3) chk("border_1_3", border, 1'b1);
         if (got.blank == 1'b0 && got.x == 9'd6 && got.y == 9'd3) chk("border_6_3", border, 1'b1);
         if (got.blank == 1'b0 && got.x == 9'd2 && got.y == 9'd2) chk("border_2_2", border, 1'b0);
      end
      if (wrapped && wraps == 1) begin
         chk("asel_wrap1", asel, 5'b01000);
         chk("hsel_wrap1", hsel, 3'd3);
      end
      if (wrapped && wraps == 5) begin
         chk("asel_wrap5", asel, 5'b00100);
         chk("hsel_wrap5", hsel, 3'd2);
      end
      if (wrapped && wraps == 8) begin
         chk("asel_wrap8", asel, 5'b00001);
         chk("hsel_wrap8", hsel, 3'd0);
      end
   endtask

   initial begin
      int n;
      reset_n = 1'b0; start = 1'b0; src_valid = 1'b0; src_data = 8'h00;
      model_reset();
      repeat (2) @(negedge clock);
      check_reset_values();
      reset_n = 1'b1;
      repeat (2) step(1'b0, 8'h00, 1'b0);

      // frame 1: continuous source
      step(1'b0, 8'h00, 1'b1);
      n = 0;
      while (m_state != ST_IDLE && n < 200) begin
         step(1'b1, 8'(n * 7 + 3), 1'b0);
         n++;
      end
      chk("frame1_cycles", n, 48 + 16 + 1);

      // frame 2: source valid every other cycle, stray start pulses during RUN
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      n = 0;
      while (m_state != ST_IDLE && n < 300) begin
         step(n % 2 == 0, 8'(n * 13 + 1), (n == 10) || (n == 40));
         n++;
      end
      chk("frame2_end_x", x_count, 9'd0);
      chk("frame2_end_y", y_count, 9'd0);

      // frame 3: reset while pixel (3,2) is on the window outputs
      step(1'b0, 8'h00, 1'b1);
      n = 0;
      while (!(m_state == ST_RUN && m_xc == 3 && m_yc == 2) && n < 200) begin
         step(1'b1, 8'(n * 5 + 9), 1'b0);
         n++;
      end
      #1 reset_n = 1'b0;
      start = 1'b0; src_valid = 1'b0;
      #1 check_reset_values();
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      step(1'b0, 8'h00, 1'b0);

      // frame 4: fresh frame after reset
      step(1'b0, 8'h00, 1'b1);
      n = 0;
      while (m_state != ST_IDLE && n < 200) begin
         step(1'b1, 8'(n * 11 + 2), 1'b0);
         n++;
      end
      chk("frame4_cycles", n, 48 + 16 + 1);
      step(1'b0, 8'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
